// File: rtl/pipeline_pkg.sv
// Shared pipeline types and defaults: fetch FSM states, IF/ID bundle, reset constants.
package pipeline_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

  // Branch targets are forced onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface instruction_fetch_if;
  import pipeline_pkg::*;

  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );

endinterface

// File: rtl/instruction_fetch_if_id_register.sv
// Generic stall/flush/load pipeline register carrying the IF/ID bundle.
module if_id_register
  import pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   stall,
  input  logic   flush,
  input  logic   load,
  input  if_id_t d,
  output if_id_t q
);

  // A bubble keeps the last PC+4 so decode still sees a sensible value.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
    end else if (!stall) begin
      if (load && !flush) begin
        q <= d;
      end else begin
        q <= '{instr: NOP_INSTR, pc_plus4: q.pc_plus4, valid: 1'b0};
      end
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// MIPS IF stage: owns the PC, fetches over a valid/ready imem bus and drives IF/ID.
module instruction_fetch
  import pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stallF,
  input  logic                 PCSrcD,
  input  logic [XLEN-1:0]      PCbranchD,
  instruction_fetch_if.master  imem,
  output logic [XLEN-1:0]      instrD,
  output logic [XLEN-1:0]      PCPlus4D,
  output logic                 validD,
  output logic [XLEN-1:0]      pcF
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] hold_q, hold_d;
  logic            squash_q, squash_d;

  logic            redirect_c;
  logic            load_c;
  logic [XLEN-1:0] load_word_c;
  logic [XLEN-1:0] pc_plus4_c;
  logic [XLEN-1:0] target_c;
  if_id_t          if_id_d;
  if_id_t          if_id_q;

  // Stall wins over a redirect; the hazard unit never relies on both together.
  assign redirect_c = PCSrcD && !stallF;
  assign pc_plus4_c = pc_q + XLEN'(4);
  assign target_c   = word_align(PCbranchD);

  // State register; an outstanding response at reset must be dropped when it lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      hold_q   <= '0;
      squash_q <= (state_q == WAIT) || squash_q;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      hold_q   <= hold_d;
      squash_q <= squash_d;
    end
  end

  // Next-state, PC and IF/ID load decisions.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_d      = hold_q;
    squash_d    = squash_q;
    load_c      = 1'b0;
    load_word_c = imem.imem_resp_data;

    unique case (state_q)
      FETCH: begin
        // A stale response from before reset may still arrive here.
        if (imem.imem_resp_valid) begin
          squash_d = 1'b0;
        end
        if (imem.imem_req_ready) begin
          state_d = WAIT;
        end
        if (redirect_c) begin
          pc_d = target_c;
          if (imem.imem_req_ready) begin
            squash_d = 1'b1;
          end
        end
      end

      WAIT: begin
        if (redirect_c) begin
          pc_d = target_c;
          // A response landing with the redirect is consumed and discarded here.
          if (imem.imem_resp_valid) begin
            squash_d = 1'b0;
            state_d  = FETCH;
          end else begin
            squash_d = 1'b1;
          end
        end else if (imem.imem_resp_valid) begin
          if (squash_q) begin
            squash_d = 1'b0;
            state_d  = FETCH;
          end else if (!stallF) begin
            load_c  = 1'b1;
            pc_d    = pc_plus4_c;
            state_d = FETCH;
          end else begin
            hold_d  = imem.imem_resp_data;
            state_d = HOLD;
          end
        end
      end

      HOLD: begin
        if (redirect_c) begin
          pc_d    = target_c;
          state_d = FETCH;
        end else if (!stallF) begin
          load_c      = 1'b1;
          load_word_c = hold_q;
          pc_d        = pc_plus4_c;
          state_d     = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  assign imem.imem_req_valid = (state_q == FETCH) && !rst;
  assign imem.imem_req_addr  = pc_q;

  assign if_id_d = '{instr: load_word_c, pc_plus4: pc_plus4_c, valid: 1'b1};

  if_id_register #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk   (clk),
    .rst   (rst),
    .stall (stallF),
    .flush (redirect_c),
    .load  (load_c),
    .d     (if_id_d),
    .q     (if_id_q)
  );

  assign instrD   = if_id_q.instr;
  assign PCPlus4D = if_id_q.pc_plus4;
  assign validD   = if_id_q.valid;
  assign pcF      = pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed per-cycle vector table, then random traffic vs a program-order model.
module tb_instruction_fetch;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallF;
  logic        PCSrcD;
  logic [31:0] PCbranchD;
  logic [31:0] instrD;
  logic [31:0] PCPlus4D;
  logic        validD;
  logic [31:0] pcF;

  instruction_fetch_if imem ();

  instruction_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .stallF    (stallF),
    .PCSrcD    (PCSrcD),
    .PCbranchD (PCbranchD),
    .imem      (imem),
    .instrD    (instrD),
    .PCPlus4D  (PCPlus4D),
    .validD    (validD),
    .pcF       (pcF)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Instruction memory contents used by the random phase.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_5A5A;
  endfunction

  typedef struct {
    logic        r, s, b;
    logic [31:0] tgt;
    logic        rdy, rv;
    logic [31:0] rdata;
    logic        chk, e_rv;
    logic [31:0] e_addr;
    logic        e_vd;
    logic [31:0] e_instr, e_pc4, e_pcf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic r, input logic s, input logic b, input logic [31:0] tgt,
                             input logic rdy, input logic rv, input logic [31:0] rdata,
                             input logic chk, input logic e_rv, input logic [31:0] e_addr,
                             input logic e_vd, input logic [31:0] e_instr,
                             input logic [31:0] e_pc4, input logic [31:0] e_pcf);
    vec_t t;
    t.r = r; t.s = s; t.b = b; t.tgt = tgt; t.rdy = rdy; t.rv = rv; t.rdata = rdata;
    t.chk = chk; t.e_rv = e_rv; t.e_addr = e_addr; t.e_vd = e_vd;
    t.e_instr = e_instr; t.e_pc4 = e_pc4; t.e_pcf = e_pcf;
    return t;
  endfunction

  localparam logic [31:0] A0  = 32'h0043_0820;
  localparam logic [31:0] A4  = 32'h8C01_0004;
  localparam logic [31:0] A8  = 32'h0022_1820;
  localparam logic [31:0] A12 = 32'hDEAD_BEEF;
  localparam logic [31:0] A40 = 32'h2042_0001;

  // Random-phase state
  logic [31:0] exp_instr, exp_pc4, exp_pc;
  logic        exp_vd;
  logic        pend;
  logic [31:0] pend_addr;
  int          cnt;
  int          ndeliv;
  logic        pre_rv;
  logic [31:0] pre_addr;
  logic        stab_pend;
  logic [31:0] stab_addr;

  initial begin
    rst = 1'b1; stallF = 1'b0; PCSrcD = 1'b0; PCBranch_init();
    imem.imem_req_ready = 1'b0; imem.imem_resp_valid = 1'b0; imem.imem_resp_data = '0;

    //           r  s  b  tgt           rdy rv rdata          chk erv addr          vd instr        pc4           pcF
    tbl.push_back(v(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,       32'h0,        32'h0));
    tbl.push_back(v(1, 0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,       32'h0,        32'h0));
    tbl.push_back(v(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'h0,        0, 32'h0,       32'h0,        32'h0));
    tbl.push_back(v(0, 0, 0, 32'h0,        0, 1, A0,           1, 0, 32'h0,        0, 32'h0,       32'h0,        32'h0));
    tbl.push_back(v(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'h4,        1, A0,          32'h4,        32'h4));
    tbl.push_back(v(0, 1, 0, 32'h0,        0, 1, A4,           1, 0, 32'h0,        0, 32'h0,       32'h4,        32'h4));
    tbl.push_back(v(0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,       32'h4,        32'h4));
    tbl.push_back(v(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,       32'h4,        32'h4));
    tbl.push_back(v(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h8,        1, A4,          32'h8,        32'h8));
    tbl.push_back(v(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h8,        0, 32'h0,       32'h8,        32'h8));
    tbl.push_back(v(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h8,        0, 32'h0,       32'h8,        32'h8));
    tbl.push_back(v(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'h8,        0, 32'h0,       32'h8,        32'h8));
    tbl.push_back(v(0, 0, 0, 32'h0,        0, 1, A8,           1, 0, 32'h0,        0, 32'h0,       32'h8,        32'h8));
    tbl.push_back(v(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'hC,        1, A8,          32'hC,        32'hC));
    tbl.push_back(v(0, 0, 1, 32'h43,       0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,       32'hC,        32'hC));
    tbl.push_back(v(0, 0, 0, 32'h0,        0, 1, A12,          1, 0, 32'h0,        0, 32'h0,       32'hC,        32'h40));
    tbl.push_back(v(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'h40,       0, 32'h0,       32'hC,        32'h40));
    tbl.push_back(v(0, 0, 0, 32'h0,        0, 1, A40,          1, 0, 32'h0,        0, 32'h0,       32'hC,        32'h40));
    tbl.push_back(v(0, 1, 1, 32'h100,      0, 0, 32'h0,        1, 1, 32'h44,       1, A40,         32'h44,       32'h44));
    tbl.push_back(v(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h44,       1, A40,         32'h44,       32'h44));
    tbl.push_back(v(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'h44,       0, 32'h0,       32'h44,       32'h44));
    tbl.push_back(v(1, 0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,       32'h44,       32'h44));
    tbl.push_back(v(0, 0, 0, 32'h0,        0, 1, 32'hBAD0_BAD0, 1, 1, 32'h0,       0, 32'h0,       32'h0,        32'h0));
    tbl.push_back(v(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'h0,        0, 32'h0,       32'h0,        32'h0));
    tbl.push_back(v(0, 0, 0, 32'h0,        0, 1, A0,           1, 0, 32'h0,        0, 32'h0,       32'h0,        32'h0));
    tbl.push_back(v(0, 0, 1, 32'hFFFF_FFFF, 0, 0, 32'h0,       1, 1, 32'h4,        1, A0,          32'h4,        32'h4));
    tbl.push_back(v(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'hFFFF_FFFC, 0, 32'h0,      32'h4,        32'hFFFF_FFFC));
    tbl.push_back(v(0, 0, 0, 32'h0,        0, 1, 32'h1111_2222, 1, 0, 32'h0,       0, 32'h0,       32'h4,        32'hFFFF_FFFC));
    tbl.push_back(v(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h0,        1, 32'h1111_2222, 32'h0,      32'h0));

    // Directed phase: bench acts as the memory, one record per cycle.
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = tbl[i].r; stallF = tbl[i].s; PCSrcD = tbl[i].b; PCbranchD = tbl[i].tgt;
      imem.imem_req_ready = tbl[i].rdy;
      imem.imem_resp_valid = tbl[i].rv;
      imem.imem_resp_data = tbl[i].rdata;
      #1;
      if (tbl[i].chk) begin
        check1($sformatf("vec%0d req_valid", i), imem.imem_req_valid, tbl[i].e_rv);
        if (tbl[i].e_rv)
          check32($sformatf("vec%0d req_addr", i), imem.imem_req_addr, tbl[i].e_addr);
        check1($sformatf("vec%0d validD", i), validD, tbl[i].e_vd);
        check32($sformatf("vec%0d instrD", i), instrD, tbl[i].e_instr);
        check32($sformatf("vec%0d PCPlus4D", i), PCPlus4D, tbl[i].e_pc4);
        check32($sformatf("vec%0d pcF", i), pcF, tbl[i].e_pcf);
      end
    end

    // Random phase: restart cleanly, then compare against the program-order model.
    @(negedge clk);
    rst = 1'b1; stallF = 1'b0; PCSrcD = 1'b0;
    imem.imem_req_ready = 1'b0; imem.imem_resp_valid = 1'b0;
    @(negedge clk);
    exp_instr = DEFAULT_NOP_INSTR; exp_pc4 = '0; exp_vd = 1'b0; exp_pc = DEFAULT_RESET_PC;
    pend = 1'b0; pend_addr = '0; cnt = 0; ndeliv = 0; stab_pend = 1'b0; stab_addr = '0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc > 0) @(negedge clk);
      rst       = (cyc == 0) || ($urandom_range(0, 199) == 0);
      stallF    = ($urandom_range(0, 3) == 0);
      PCSrcD    = ($urandom_range(0, 9) == 0);
      PCbranchD = $urandom;
      if (pend && cnt == 0) begin
        imem.imem_resp_valid = 1'b1;
        imem.imem_resp_data  = mem_word(pend_addr);
        pend = 1'b0;
      end else begin
        imem.imem_resp_valid = 1'b0;
        imem.imem_resp_data  = $urandom;
        if (pend) cnt--;
      end
      imem.imem_req_ready = !pend && ($urandom_range(0, 2) != 0);
      #1;
      pre_rv   = imem.imem_req_valid;
      pre_addr = imem.imem_req_addr;
      if (rst) check1("rst req_valid", pre_rv, 1'b0);
      else if (stab_pend) begin
        check1("stable req_valid", pre_rv, 1'b1);
        check32("stable req_addr", pre_addr, stab_addr);
      end
      stab_pend = pre_rv && !imem.imem_req_ready && !rst && !(PCSrcD && !stallF);
      stab_addr = pre_addr;

      @(posedge clk);
      if (pre_rv && imem.imem_req_ready) begin
        pend = 1'b1; pend_addr = pre_addr; cnt = $urandom_range(0, 2);
      end
      #1;
      if (rst) begin
        exp_instr = DEFAULT_NOP_INSTR; exp_pc4 = '0; exp_vd = 1'b0; exp_pc = DEFAULT_RESET_PC;
        stab_pend = 1'b0;
      end else if (!stallF) begin
        if (PCSrcD) begin
          exp_instr = DEFAULT_NOP_INSTR; exp_vd = 1'b0;
          exp_pc = {PCbranchD[31:2], 2'b00};
        end else if (validD === 1'b1) begin
          exp_instr = mem_word(exp_pc); exp_pc4 = exp_pc + 32'd4; exp_vd = 1'b1;
          exp_pc = exp_pc + 32'd4; ndeliv++;
        end else begin
          exp_instr = DEFAULT_NOP_INSTR; exp_vd = 1'b0;
        end
      end
      check1("rnd validD", validD, exp_vd);
      check32("rnd instrD", instrD, exp_instr);
      check32("rnd PCPlus4D", PCPlus4D, exp_pc4);
      check32("rnd pcF", pcF, exp_pc);
    end

    check1("rnd progress", (ndeliv >= 100), 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  task automatic PCBranch_init();
    PCbranchD = '0;
  endtask

endmodule
